jtpopeye_objdma: RTL and testbench
==================================

JTPOPEYE_OBJDMA -- requirements
Module: jtpopeye_objdma

Interface
REQ-001 SHALL have parameter OBJ_N, default 64: number of objects per frame (power of two, 2..256).
REQ-002 SHALL have parameter OBJ_B, default 4: bytes per object (1..8).
REQ-003 SHALL have parameter AW, default 12: CPU-side address width.
REQ-004 SHALL have parameter BASE, default 12'hC00: first source address (AW bits).
REQ-005 SHALL have port clk, input, 1: the single system clock. All state is on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port cen, input, 1: CPU clock enable. Every bus-side state change is qualified by cen.
REQ-008 SHALL have port VB, input, 1: vertical blank.
REQ-009 SHALL have port enable, input, 1: a VB rising edge arms a transfer only when enable=1.
REQ-010 SHALL have port busrq_n, output, 1: bus request, active-low.
REQ-011 SHALL have port busak_n, input, 1: bus acknowledge, active-low.
REQ-012 SHALL have port dma_cs, output, 1: source read strobe.
REQ-013 SHALL have port dma_addr, output, AW: source address.
REQ-014 SHALL have port dma_din, input, 8: source data. It is valid one cen after the address.
REQ-015 SHALL have port obj_idx, input, log2(OBJ_N): renderer object select.
REQ-016 SHALL have port obj_data, output, 8*OBJ_B: front-bank object. Byte 0 is in bits [7:0].
REQ-017 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-018 SHALL have port ovr, output, 1: sticky abort flag.

Function
REQ-019 SHALL implement a double-buffered object store of 2 banks x OBJ_N x OBJ_B bytes. The renderer reads the front bank. The DMA writes the back bank.
REQ-020 SHALL register obj_data from the front bank at obj_idx with 1 clk latency, independent of cen and of the DMA state.
REQ-021 SHALL implement states IDLE, REQ, XFER, DRAIN, REL.
REQ-022 IDLE -> REQ: on a clk where VB=1, the registered VB=0, and enable=1.
REQ-023 REQ: busrq_n=0. On cen with busak_n=0, SHALL go to XFER with cnt=0.
REQ-024 XFER, each cen:
- dma_cs=1 and dma_addr=BASE+cnt (modulo 2^AW).
- if cnt>0, dma_din is written to back[cnt-1] (object (cnt-1)/OBJ_B, byte (cnt-1)%OBJ_B).
- cnt then increments.
REQ-025 After address OBJ_N*OBJ_B-1, SHALL go to DRAIN with dma_cs=0. On the next cen it writes the last byte and goes to REL.
REQ-026 REL: busrq_n=1 and bank select toggles, both on the same cen. SHALL then return to IDLE. Total time from grant to release is OBJ_N*OBJ_B+2 cens.
REQ-027 dma_cs SHALL be 0 outside XFER. dma_addr SHALL hold its last value outside XFER.
REQ-028 A VB falling edge in REQ, XFER or DRAIN SHALL abort:
- next clk: IDLE, busrq_n=1, dma_cs=0, ovr=1.
- bank select does not toggle; the front bank is unchanged.
REQ-029 A VB rising edge while not in IDLE SHALL be ignored.
REQ-030 A VB falling edge on the same clk as REL SHALL complete normally, with no abort.
REQ-031 busak_n going high during XFER SHALL stall: cnt holds and dma_cs=0 until busak_n=0 again. The VB-fall abort still applies.
REQ-032 ovr SHALL clear only on a completed transfer (REL) or on reset.
REQ-033 enable=0 SHALL NOT abort a transfer already in progress.

Reset
REQ-034 While rst=1, and on rst falling:
- state=IDLE, busrq_n=1, dma_cs=0, dma_addr=BASE.
- busy=0, ovr=0, bank select=0 (front=bank 0), cnt=0.
- obj_data=0.
REQ-035 Reset mid-transfer SHALL release the bus immediately, asynchronously. Buffer contents are not cleared.

Verification
Bench parameters for all scenarios: OBJ_N=4, OBJ_B=4, BASE=12'hC00, source RAM returns addr[7:0], busak_n follows busrq_n one cen later.
REQ-036 Basic transfer:
- stimulus: VB rise, enable=1.
- response: busrq_n low; addresses C00..C0F on 16 consecutive cens; release 18 cens after grant; bank toggles.
- then obj_idx=2 gives obj_data=32'h0B0A0908 after 1 clk.
REQ-037 Second frame:
- stimulus: RAM content changed to ~addr, second VB.
- response: front bank now holds the new data; obj_idx=0 gives 32'hFCFDFEFF.
- old data stays visible until the swap.
REQ-038 Abort:
- stimulus: VB falls after 6 XFER cens.
- response: busrq_n=1 next clk; ovr=1; obj_data unchanged.
- then a full transfer next frame clears ovr.
REQ-039 Bus stall:
- stimulus: busak_n forced high for 5 cens mid-XFER.
- response: no address skipped or duplicated; final buffer identical to REQ-036.
REQ-040 Reset:
- stimulus: rst pulsed at cnt=9.
- response: busrq_n=1 and dma_cs=0 immediately; busy=0; next VB performs a full transfer into bank 1.
REQ-041 Disabled:
- stimulus: enable=0 at VB rise.
- response: busrq_n stays 1 for the whole frame.

Source files
------------

// File: rtl/jtpopeye_objdma.sv
// Object-table DMA: copies OBJ_N*OBJ_B bytes from CPU space into the back bank
// of a double-buffered object store during vertical blank, then swaps banks.
module jtpopeye_objdma #(
    parameter int              OBJ_N = 64,
    parameter int              OBJ_B = 4,
    parameter int              AW    = 12,
    parameter logic [AW-1:0]   BASE  = 12'hC00
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cen,
    input  logic                       VB,
    input  logic                       enable,
    output logic                       busrq_n,
    input  logic                       busak_n,
    output logic                       dma_cs,
    output logic [AW-1:0]              dma_addr,
    input  logic [7:0]                 dma_din,
    input  logic [$clog2(OBJ_N)-1:0]   obj_idx,
    output logic [8*OBJ_B-1:0]         obj_data,
    output logic                       busy,
    output logic                       ovr
);

    localparam int IW    = $clog2(OBJ_N);
    localparam int BW    = (OBJ_B > 1) ? $clog2(OBJ_B) : 1;
    localparam int TOTAL = OBJ_N * OBJ_B;
    localparam int CW    = $clog2(TOTAL + 1);

    typedef enum logic [2:0] {IDLE, REQ, XFER, DRAIN, REL} state_t;

    state_t          state;
    logic            vb_l;
    logic            bank_sel;
    logic            pend;
    logic [CW-1:0]   nxt;
    logic [IW-1:0]   wobj;
    logic [BW-1:0]   wbyte;
    logic [7:0]      mem [0:1][0:OBJ_N-1][0:OBJ_B-1];

    logic vb_rise, vb_fall, abort, wr_en;

    assign vb_rise = VB & ~vb_l;
    assign vb_fall = ~VB & vb_l;
    assign abort   = vb_fall & (state == REQ || state == XFER || state == DRAIN);
    // pend marks that dma_din carries the byte read during the previous cen period
    assign wr_en   = cen & pend & ~abort & (state == XFER || state == DRAIN);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            vb_l     <= 1'b0;
            busrq_n  <= 1'b1;
            dma_cs   <= 1'b0;
            dma_addr <= BASE;
            ovr      <= 1'b0;
            bank_sel <= 1'b0;
            pend     <= 1'b0;
            nxt      <= '0;
            wobj     <= '0;
            wbyte    <= '0;
        end else begin
            vb_l <= VB;
            if (abort) begin
                state   <= IDLE;
                busrq_n <= 1'b1;
                dma_cs  <= 1'b0;
                pend    <= 1'b0;
                ovr     <= 1'b1;
            end else if (state == IDLE) begin
                if (vb_rise && enable) begin
                    state   <= REQ;
                    busrq_n <= 1'b0;
                end
            end else if (cen) begin
                if (wr_en) begin
                    if (wbyte == BW'(OBJ_B - 1)) begin
                        wbyte <= '0;
                        wobj  <= wobj + IW'(1);
                    end else begin
                        wbyte <= wbyte + BW'(1);
                    end
                end
                case (state)
                    REQ: begin
                        if (!busak_n) begin
                            state    <= XFER;
                            dma_cs   <= 1'b1;
                            dma_addr <= BASE;
                            nxt      <= CW'(1);
                            wobj     <= '0;
                            wbyte    <= '0;
                            pend     <= 1'b0;
                        end
                    end
                    XFER: begin
                        pend <= dma_cs;
                        // A lost grant only suppresses the next read; nxt stays put
                        if (nxt == CW'(TOTAL)) begin
                            state  <= DRAIN;
                            dma_cs <= 1'b0;
                        end else if (!busak_n) begin
                            dma_cs   <= 1'b1;
                            dma_addr <= BASE + AW'(nxt);
                            nxt      <= nxt + CW'(1);
                        end else begin
                            dma_cs <= 1'b0;
                        end
                    end
                    DRAIN: begin
                        pend  <= 1'b0;
                        state <= REL;
                    end
                    REL: begin
                        busrq_n  <= 1'b1;
                        bank_sel <= ~bank_sel;
                        ovr      <= 1'b0;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Storage is deliberately not reset so a reset mid-transfer keeps both banks
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[~bank_sel][wobj][wbyte] <= dma_din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            obj_data <= '0;
        end else begin
            for (int b = 0; b < OBJ_B; b++)
                obj_data[8*b +: 8] <= mem[bank_sel][obj_idx][b];
        end
    end

endmodule

// File: tb/tb_jtpopeye_objdma.sv
// Directed self-checking bench for jtpopeye_objdma with OBJ_N=4, OBJ_B=4.
module tb_jtpopeye_objdma;

    logic        clk = 1'b0;
    logic        rst, cen, VB, enable, busak_n;
    logic        busrq_n, dma_cs, busy, ovr;
    logic [11:0] dma_addr;
    logic [7:0]  dma_din;
    logic [1:0]  obj_idx;
    logic [31:0] obj_data;

    int          tests     = 0;
    int          failures  = 0;
    int          cenCount  = 0;
    int          stallCens = 0;
    bit          ramInvert = 1'b0;
    logic [11:0] prevAddr  = 12'hC00;
    logic [11:0] addrLog [$];
    logic [31:0] midData;
    logic        lowSeen;

    jtpopeye_objdma #(.OBJ_N(4), .OBJ_B(4), .AW(12), .BASE(12'hC00)) dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .VB       (VB),
        .enable   (enable),
        .busrq_n  (busrq_n),
        .busak_n  (busak_n),
        .dma_cs   (dma_cs),
        .dma_addr (dma_addr),
        .dma_din  (dma_din),
        .obj_idx  (obj_idx),
        .obj_data (obj_data),
        .busy     (busy),
        .ovr      (ovr)
    );

    always #5 clk = ~clk;

    // Bus environment: cen one clk in three, synchronous source RAM, grant one cen behind request
    initial begin
        int phase;
        phase   = 0;
        cen     = 1'b0;
        busak_n = 1'b1;
        dma_din = 8'h00;
        forever begin
            @(negedge clk);
            if (cen) begin
                cenCount++;
                if (dma_cs) addrLog.push_back(dma_addr);
                dma_din  = ramInvert ? ~prevAddr[7:0] : prevAddr[7:0];
                prevAddr = dma_addr;
                if (stallCens > 0) begin
                    busak_n = 1'b1;
                    stallCens--;
                end else begin
                    busak_n = busrq_n;
                end
            end
            phase = (phase == 2) ? 0 : phase + 1;
            cen   = (phase == 0);
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitClk(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic vb, input logic en);
        VB     = vb;
        enable = en;
        waitClk(1);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic runTransfer(input string tag, input int expCens, input int stallAt,
                               input int disableAt, output logic [31:0] mid);
        int   g;
        logic seen, stallDone, disDone;
        addrLog.delete();
        mid       = '0;
        stallDone = 1'b0;
        disDone   = 1'b0;
        applyStimulus(1'b1, 1'b1);
        checkOutput({tag, "_busrq_low"}, busrq_n, 32'd0);
        checkOutput({tag, "_busy"}, busy, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (dma_cs) begin
                seen = 1'b1;
                break;
            end
            waitClk(1);
        end
        checkOutput({tag, "_grant"}, seen, 32'd1);
        g    = cenCount;
        seen = 1'b0;
        for (int i = 0; i < 900; i++) begin
            if (busrq_n) begin
                seen = 1'b1;
                break;
            end
            if (stallAt > 0 && !stallDone && addrLog.size() >= stallAt) begin
                stallCens = 5;
                stallDone = 1'b1;
            end
            if (disableAt > 0 && !disDone && addrLog.size() >= disableAt) begin
                enable  = 1'b0;
                disDone = 1'b1;
            end
            if (addrLog.size() == 8) mid = obj_data;
            waitClk(1);
        end
        checkOutput({tag, "_release"}, seen, 32'd1);
        checkOutput({tag, "_cens"}, cenCount - g, expCens);
        checkOutput({tag, "_naddr"}, addrLog.size(), 32'd16);
        for (int i = 0; i < 16 && i < addrLog.size(); i++)
            checkOutput({tag, "_addr"}, addrLog[i], 32'hC00 + i);
        applyStimulus(1'b0, 1'b1);
        waitClk(4);
    endtask

    initial begin
        rst     = 1'b1;
        VB      = 1'b0;
        enable  = 1'b0;
        obj_idx = 2'd0;
        waitClk(3);
        checkOutput("rst_busrq", busrq_n, 32'd1);
        checkOutput("rst_cs", dma_cs, 32'd0);
        checkOutput("rst_addr", dma_addr, 32'hC00);
        checkOutput("rst_busy", busy, 32'd0);
        checkOutput("rst_ovr", ovr, 32'd0);
        checkOutput("rst_obj", obj_data, 32'd0);
        rst = 1'b0;
        waitClk(2);
        checkOutput("idle_busrq", busrq_n, 32'd1);

        // Basic transfer of addr[7:0] into bank 1
        ramInvert = 1'b0;
        runTransfer("basic", 18, 0, 0, midData);
        checkOutput("basic_busy_end", busy, 32'd0);
        checkOutput("basic_ovr", ovr, 32'd0);
        obj_idx = 2'd2;
        waitClk(1);
        checkOutput("basic_obj2", obj_data, 32'h0B0A0908);
        obj_idx = 2'd0;
        waitClk(1);
        checkOutput("basic_obj0", obj_data, 32'h03020100);

        // Second frame with inverted RAM; old data visible until the swap
        ramInvert = 1'b1;
        runTransfer("frame2", 18, 0, 0, midData);
        checkOutput("frame2_old_visible", midData, 32'h03020100);
        waitClk(1);
        checkOutput("frame2_obj0", obj_data, 32'hFCFDFEFF);
        obj_idx = 2'd3;
        waitClk(1);
        checkOutput("frame2_obj3", obj_data, 32'hF0F1F2F3);
        obj_idx = 2'd0;

        // Abort by VB falling after 6 reads
        ramInvert = 1'b0;
        addrLog.delete();
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 600 && addrLog.size() < 6; i++) waitClk(1);
        checkOutput("abort_reached", addrLog.size() >= 6, 32'd1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("abort_busrq", busrq_n, 32'd1);
        checkOutput("abort_cs", dma_cs, 32'd0);
        checkOutput("abort_ovr", ovr, 32'd1);
        checkOutput("abort_busy", busy, 32'd0);
        checkOutput("abort_obj0", obj_data, 32'hFCFDFEFF);
        waitClk(20);
        checkOutput("abort_ovr_sticky", ovr, 32'd1);
        checkOutput("abort_obj0_hold", obj_data, 32'hFCFDFEFF);
        runTransfer("recover", 18, 0, 0, midData);
        checkOutput("recover_ovr", ovr, 32'd0);
        checkOutput("recover_obj0", obj_data, 32'h03020100);

        // Grant withdrawn for 5 cens mid-transfer
        ramInvert = 1'b0;
        runTransfer("stall", 23, 6, 0, midData);
        obj_idx = 2'd2;
        waitClk(2);
        checkOutput("stall_obj2", obj_data, 32'h0B0A0908);
        obj_idx = 2'd1;
        waitClk(1);
        checkOutput("stall_obj1", obj_data, 32'h07060504);
        obj_idx = 2'd2;

        // Asynchronous reset at cnt=9
        ramInvert = 1'b1;
        addrLog.delete();
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 600 && addrLog.size() < 9; i++) waitClk(1);
        checkOutput("reset_reached", addrLog.size() >= 9, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("reset_busrq", busrq_n, 32'd1);
        checkOutput("reset_cs", dma_cs, 32'd0);
        checkOutput("reset_busy", busy, 32'd0);
        checkOutput("reset_addr", dma_addr, 32'hC00);
        checkOutput("reset_obj", obj_data, 32'd0);
        VB = 1'b0;
        waitClk(2);
        rst = 1'b0;
        waitClk(1);
        checkOutput("reset_keeps_bank0", obj_data, 32'h0B0A0908);
        obj_idx = 2'd0;
        runTransfer("after_reset", 18, 0, 4, midData);
        checkOutput("after_reset_obj0", obj_data, 32'hFCFDFEFF);
        checkOutput("after_reset_ovr", ovr, 32'd0);

        // VB rise with enable low leaves the bus alone
        lowSeen = 1'b0;
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 150; i++) begin
            if (!busrq_n || busy) lowSeen = 1'b1;
            waitClk(1);
        end
        checkOutput("disabled_no_req", lowSeen, 32'd0);
        applyStimulus(1'b0, 1'b0);
        waitClk(4);
        checkOutput("disabled_obj0", obj_data, 32'hFCFDFEFF);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
